// File: rtl/frame_buffer_sink.sv
// ---------------------------------------------------------------------------
// frame_buffer_sink
//   Receiving end of the drawing-engine pixel-write interface. Paces the
//   engine with wr_en, writes accepted pixels into a double-buffered frame
//   RAM (back bank = buffer_using) and serves scan-out reads from the front
//   bank (~buffer_using). Banks swap on a frame start only once the engine
//   has signalled a completed frame.
//
// Ports
//   Clk, Reset_n          clock (posedge) and async active-low reset
//   frame_clk_edge[1:0]   {prev,cur} frame clock sample, 2'b01 = frame start
//   frame_done            engine finished level, rising edge = frame complete
//   draw_x/draw_y/color   pixel offered by the engine
//   wr_en                 pixel on draw_* is consumed in any cycle wr_en=1
//   buffer_using          current back (write) bank
//   rd_req, rd_x, rd_y    scan-out read request and coordinates
//   rd_data, rd_valid     scan-out result, two cycles after rd_req
//   mem_addr/wdata/we     registered frame RAM port
//   mem_rdata             frame RAM read data, one cycle after mem_addr
//   frames_dropped        saturating count of frame starts without a frame
//   pix_written           in-range pixels written into the current frame
// ---------------------------------------------------------------------------
module frame_buffer_sink #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 18
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [1:0]        frame_clk_edge,
  input  logic              frame_done,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [7:0]        draw_color,
  output logic              wr_en,
  output logic              buffer_using,
  input  logic              rd_req,
  input  logic [9:0]        rd_x,
  input  logic [9:0]        rd_y,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        frames_dropped,
  output logic [16:0]       pix_written
);

  localparam int BANK_WORDS = H_RES * V_RES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic fd_hist_r;
  logic edge_s;
  logic fd_rise_s;
  logic swap_s;
  logic drop_s;
  logic clear_s;
  logic wr_inrange_s;
  logic rd_inrange_s;
  logic rd_pend_r;
  logic rd_oor_r;
  logic rd_zero_r;

  // Linear frame RAM address of pixel (x,y) inside the selected bank.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic bank,
                                                  input logic [9:0] x,
                                                  input logic [9:0] y);
    logic [ADDR_W-1:0] base;
    if (bank) begin
      base = ADDR_W'(BANK_WORDS);
    end else begin
      base = '0;
    end
    return base + ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  assign edge_s       = (frame_clk_edge == 2'b01);
  assign fd_rise_s    = frame_done & ~fd_hist_r;
  assign wr_inrange_s = (draw_x < 10'(H_RES)) && (draw_y < 10'(V_RES));
  assign rd_inrange_s = (rd_x < 10'(H_RES)) && (rd_y < 10'(V_RES));

  // State register and frame_done history (history resets high so a level
  // already high out of reset is not taken as a completed frame).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      fd_hist_r <= 1'b1;
    end else begin
      state_r   <= next_state_s;
      fd_hist_r <= frame_done;
    end
  end

  // Next-state logic plus swap / drop / counter-clear decisions.
  always_comb begin
    next_state_s = state_r;
    swap_s       = 1'b0;
    drop_s       = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (edge_s) begin
          next_state_s = ST_DRAW;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (edge_s) begin
          // A completion arriving together with the frame start still counts.
          next_state_s = ST_DRAW;
          clear_s      = 1'b1;
          if (fd_rise_s) begin
            swap_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else if (fd_rise_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRAW;
        end
      end
      ST_DONE: begin
        if (edge_s) begin
          next_state_s = ST_DRAW;
          swap_s       = 1'b1;
          clear_s      = 1'b1;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Engine pacing: reads own the memory port, and no pixel is taken in a
  // frame-start cycle so every accepted pixel belongs to a known bank.
  always_comb begin
    wr_en = 1'b0;
    if ((state_r == ST_DRAW) && !rd_req && !edge_s) begin
      wr_en = 1'b1;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Bank selection and frame statistics.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      buffer_using   <= 1'b0;
      frames_dropped <= 8'd0;
      pix_written    <= 17'd0;
    end else begin
      if (swap_s) begin
        buffer_using <= ~buffer_using;
      end else begin
        buffer_using <= buffer_using;
      end
      if (drop_s && (frames_dropped != 8'hFF)) begin
        frames_dropped <= frames_dropped + 8'd1;
      end else begin
        frames_dropped <= frames_dropped;
      end
      if (clear_s) begin
        pix_written <= 17'd0;
      end else if (wr_en && wr_inrange_s && (pix_written != 17'h1FFFF)) begin
        pix_written <= pix_written + 17'd1;
      end else begin
        pix_written <= pix_written;
      end
    end
  end

  // Memory port: reads take precedence; an accepted pixel is issued with the
  // bank current at acceptance, so a write in flight over a swap stays put.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      rd_pend_r <= 1'b0;
      rd_oor_r  <= 1'b0;
    end else begin
      if (rd_req) begin
        mem_addr  <= calc_addr(~buffer_using, rd_x, rd_y);
        mem_wdata <= mem_wdata;
        mem_we    <= 1'b0;
        rd_pend_r <= 1'b1;
        rd_oor_r  <= ~rd_inrange_s;
      end else if (wr_en) begin
        mem_addr  <= calc_addr(buffer_using, draw_x, draw_y);
        mem_wdata <= draw_color;
        mem_we    <= wr_inrange_s;
        rd_pend_r <= 1'b0;
        rd_oor_r  <= 1'b0;
      end else begin
        mem_addr  <= mem_addr;
        mem_wdata <= mem_wdata;
        mem_we    <= 1'b0;
        rd_pend_r <= 1'b0;
        rd_oor_r  <= 1'b0;
      end
    end
  end

  // Read result strobe, aligned with the cycle the RAM presents its data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid  <= 1'b0;
      rd_zero_r <= 1'b0;
    end else begin
      rd_valid  <= rd_pend_r;
      rd_zero_r <= rd_oor_r;
    end
  end

  // RAM data arrives in the strobe cycle, so it is gated by registered
  // qualifiers rather than re-registered (which would cost a cycle).
  always_comb begin
    rd_data = 8'd0;
    if (rd_valid && !rd_zero_r) begin
      rd_data = mem_rdata;
    end else begin
      rd_data = 8'd0;
    end
  end

endmodule
